// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Holds the FSM state enum, the requester index type, the alu_8bit opcodes,
// and the packed payloads for latched commands and registered results.
package alu_share_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned OP_W   = 4;

  // Opcodes understood by alu_8bit
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index of a requester (0 or 1)
  typedef logic req_idx_t;

  // Command latched on accept
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    req_idx_t          idx;
  } cmd_t;

  // Result captured from the ALU
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             cout;
    logic             bout;
  } rsp_t;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU shared by both requesters.
// Ports: opcode (4), a/b (8) operands; alu_out (16) result,
//        cout carry-out of ADD, bout borrow-out of SUB.
// ADD yields the 9-bit sum zero-extended; SUB yields the 8-bit difference
// zero-extended; MUL yields the full 16-bit product; undefined opcodes give 0.
module alu_8bit
  import alu_share_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  alu_out,
  output logic              cout,
  output logic              bout
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    alu_out = '0;
    cout    = 1'b0;
    bout    = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_out = RES_W'(sum);
        cout    = sum[DATA_W];
      end
      OP_SUB: begin
        alu_out = RES_W'(diff[DATA_W-1:0]);
        bout    = diff[DATA_W];
      end
      OP_MUL:  alu_out = RES_W'(a) * RES_W'(b);
      OP_AND:  alu_out = RES_W'(a & b);
      OP_OR:   alu_out = RES_W'(a | b);
      OP_XOR:  alu_out = RES_W'(a ^ b);
      default: alu_out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection.
// Ports: req[1:0] request vector, last previously granted index;
//        grant selected index (combinational).
// With no request or a tie the requester not granted last wins, so the
// grant always points somewhere sensible for the ready outputs.
module rr_arb2
  import alu_share_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output req_idx_t   grant
);

  always_comb begin
    grant = ~last;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one alu_8bit between two valid/ready requesters.
// Ports: clk, rst_n (async active-low);
//        reqX_valid/ready/opcode/a/b command channels (X = 0, 1);
//        rspX_valid/ready response channels; rsp_result/rsp_cout/rsp_bout
//        shared registered result; busy (not IDLE); ops_done completed count.
// Flow: IDLE accepts a round-robin winner, EXEC captures the ALU result from
// the operand registers, RESP holds it until the owning requester takes it.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_cout,
  output logic              rsp_bout,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  state_t            state;
  req_idx_t          last;
  req_idx_t          grant;
  cmd_t              cmd;
  rsp_t              rsp;
  logic [RES_W-1:0]  alu_out;
  logic              alu_cout;
  logic              alu_bout;
  logic              accept;
  logic              rsp_hs;

  rr_arb2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .last  (last),
    .grant (grant)
  );

  // ALU sees only the latched operands
  alu_8bit u_alu (
    .opcode  (cmd.opcode),
    .a       (cmd.a),
    .b       (cmd.b),
    .alu_out (alu_out),
    .cout    (alu_cout),
    .bout    (alu_bout)
  );

  assign req0_ready = (state == ST_IDLE) && (grant == 1'b0);
  assign req1_ready = (state == ST_IDLE) && (grant == 1'b1);
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  // Only the owning requester's ready completes a response
  assign rsp_hs = (state == ST_RESP) && ((cmd.idx == 1'b1) ? rsp1_ready : rsp0_ready);

  assign rsp_result = rsp.result;
  assign rsp_cout   = rsp.cout;
  assign rsp_bout   = rsp.bout;

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last       <= 1'b1;
      cmd        <= '0;
      rsp        <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (grant == 1'b1) begin
              cmd <= '{opcode: req1_opcode, a: req1_a, b: req1_b, idx: 1'b1};
            end else begin
              cmd <= '{opcode: req0_opcode, a: req0_a, b: req0_b, idx: 1'b0};
            end
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp        <= '{result: alu_out, cout: alu_cout, bout: alu_bout};
          rsp0_valid <= (cmd.idx == 1'b0);
          rsp1_valid <= (cmd.idx == 1'b1);
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            ops_done   <= ops_done + CNT_W'(1);
            last       <= cmd.idx;
            state      <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl (counter width 4 to exercise wrap).
module tb_alu_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp_result;
  logic        rsp_cout, rsp_bout;
  logic        busy;
  logic [3:0]  ops_done;

  int checks;
  int failures;
  bit exp_last;
  int exp_ops;

  alu_share_ctrl #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opcode (req0_opcode),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opcode (req1_opcode),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_result  (rsp_result),
    .rsp_cout    (rsp_cout),
    .rsp_bout    (rsp_bout),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU behaviour in plain integer arithmetic
  function automatic void ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output bit c, output bit bw);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    r  = 16'h0;
    c  = 1'b0;
    bw = 1'b0;
    case (op)
      4'h0: begin r = 16'(ia + ib); c = (ia + ib) > 255; end
      4'h1: begin r = 16'((ia - ib + 256) % 256); bw = ia < ib; end
      4'h2: r = 16'(ia * ib);
      4'h3: r = 16'(ia & ib);
      4'h4: r = 16'(ia | ib);
      4'h5: r = 16'(ia ^ ib);
      default: r = 16'h0;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_opcode = 4'h0; req0_a = 8'h0; req0_b = 8'h0;
    req1_opcode = 4'h0; req1_a = 8'h0; req1_b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_last = 1'b1;
    exp_ops  = 0;
  endtask

  // One full operation from IDLE back to IDLE, with `stall` cycles of
  // response back-pressure during which new requests must be refused.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [3:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [3:0] o1, input logic [7:0] a1, input logic [7:0] b1,
                        input int stall);
    bit          g;
    logic [15:0] er;
    bit          ec, eb;
    g = (v0 && v1) ? !exp_last : v1;
    ref_alu(g ? o1 : o0, g ? a1 : a0, g ? b1 : b0, er, ec, eb);
    req0_valid = v0; req0_opcode = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_opcode = o1; req1_a = a1; req1_b = b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("idle_ready_granted", g ? req1_ready : req0_ready, 1);
    chk("idle_ready_other",   g ? req0_ready : req1_ready, 0);
    step();
    // EXEC: inputs scrambled to show they are not used after accept
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("exec_req_ready", {req1_ready, req0_ready}, 0);
    step();
    chk("resp_valid_pair", {rsp1_valid, rsp0_valid}, g ? 2 : 1);
    chk("resp_result", rsp_result, er);
    chk("resp_flags", {rsp_cout, rsp_bout}, {ec, eb});
    for (int i = 0; i < stall; i++) begin
      if (g) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      step();
      chk("stall_valid_pair", {rsp1_valid, rsp0_valid}, g ? 2 : 1);
      chk("stall_result", rsp_result, er);
      chk("stall_req_ready", {req1_ready, req0_ready}, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = !g; rsp1_ready = g;
    step();
    exp_last = g;
    exp_ops  = (exp_ops + 1) % 16;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("done_busy", busy, 0);
    chk("done_ops", ops_done, exp_ops);
  endtask

  task automatic run_random(input int stall_max);
    bit v0, v1;
    v0 = 1'($urandom);
    v1 = 1'($urandom);
    if (!v0 && !v1) v0 = 1'b1;
    run_op(v0, v1,
           4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           int'($urandom_range(0, stall_max)));
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Reset values
    do_reset();
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_result", rsp_result, 0);
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 1);
    chk("rst_req1_ready", req1_ready, 0);

    // Single ADD on requester 0: 0x0F + 0x01
    run_op(1, 0, 4'h0, 8'h0F, 8'h01, 4'h0, 8'h00, 8'h00, 0);
    chk("single_result_hold", rsp_result, 16'h0010);

    // Tie: req0 SUB 50-20 first, then req1 ADD 200+100
    do_reset();
    run_op(1, 1, 4'h1, 8'd50, 8'd20, 4'h0, 8'd200, 8'd100, 0);
    chk("tie_first_grant", exp_last, 0);
    run_op(1, 1, 4'h1, 8'd50, 8'd20, 4'h0, 8'd200, 8'd100, 0);
    chk("tie_second_result", rsp_result, 16'd300);
    chk("tie_ops", ops_done, 2);

    // Back-pressure on requester 1, then req0 immediately after
    run_op(0, 1, 4'h2, 8'd17, 8'd15, 4'h2, 8'd250, 8'd3, 10);
    run_op(1, 0, 4'h5, 8'hA5, 8'h3C, 4'h0, 8'h00, 8'h00, 0);

    // Reset in the middle of EXEC drops the command
    req0_valid = 1'b1; req0_opcode = 4'h0; req0_a = 8'h33; req0_b = 8'h44;
    step();
    req0_valid = 1'b0;
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("mid_ops", ops_done, 0);
    chk("mid_result", rsp_result, 0);
    step();
    rst_n = 1'b1;
    exp_last = 1'b1;
    exp_ops  = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dropped_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
    end
    chk("dropped_ops", ops_done, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) run_random(3);

    // Counter wrap at 4 bits: 17 operations leaves 1
    do_reset();
    for (int n = 0; n < 17; n++) run_random(1);
    chk("wrap_ops", ops_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
